// File: rtl/n64_response_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : n64_response_tx_if
// Brief    : Request/status bundle between response logic and the joybus
//            transmitter (payload in, line enable and status out).
// Revision : 1.0 - initial release
// ============================================================================
interface n64_response_tx_if #(
    parameter int MAX_BYTES = 4
);
    logic                   start;
    logic [8*MAX_BYTES-1:0] tx_data;
    logic [7:0]             tx_len;
    logic                   data_oe;
    logic                   busy;
    logic                   done;

    modport master (
        output start, tx_data, tx_len,
        input  data_oe, busy, done
    );

    modport slave (
        input  start, tx_data, tx_len,
        output data_oe, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/n64_response_tx.sv
`default_nettype none
// ============================================================================
// Module   : n64_response_tx
// Brief    : Controller-side N64 joybus transmitter. Serialises 1..MAX_BYTES
//            bytes in line coding plus stop bit; drives an open-drain enable.
//            Optional turnaround guard enabled by defining N64_TX_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module n64_response_tx #(
    parameter int MAX_BYTES   = 4,
    parameter int CLKS_PER_US = 4,
    parameter int GUARD_US    = 2
) (
    input  wire               sample_clk,
    input  wire               rst,
    n64_response_tx_if.slave  bus
);

    localparam int c_DATA_W    = 8 * MAX_BYTES;
    localparam int c_GUARD_CYC = GUARD_US * CLKS_PER_US;
    localparam int c_LONG_CYC  = 3 * CLKS_PER_US;
    localparam int c_PH_MAX    = (c_GUARD_CYC > c_LONG_CYC) ? c_GUARD_CYC : c_LONG_CYC;
    localparam int c_PW        = $clog2(c_PH_MAX);
    localparam int c_BW        = $clog2(c_DATA_W + 1);

    localparam logic [c_PW-1:0] c_SHORT_LAST = c_PW'(CLKS_PER_US - 1);
    localparam logic [c_PW-1:0] c_LONG_LAST  = c_PW'(c_LONG_CYC - 1);
    localparam logic [c_PW-1:0] c_STOP_LAST  = c_PW'(2 * CLKS_PER_US - 1);
`ifdef N64_TX_GUARD_EN
    localparam logic [c_PW-1:0] c_GUARD_LAST = c_PW'(c_GUARD_CYC - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
`ifdef N64_TX_GUARD_EN
        S_GUARD    = 3'd1,
`endif
        S_BIT_LOW  = 3'd2,
        S_BIT_HIGH = 3'd3,
        S_STOP_LOW = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_PW-1:0]       r_phase;
    logic [c_PW-1:0]       w_phase_nxt;
    logic [c_BW-1:0]       r_bits;
    logic [c_BW-1:0]       w_bits_nxt;
    logic [c_DATA_W-1:0]   r_shift;
    logic [c_DATA_W-1:0]   w_shift_nxt;
    logic                  r_data_oe;
    logic                  r_busy;
    logic                  r_done;

    logic [c_BW-1:0]       w_nbits;
    logic [c_PW-1:0]       w_low_last;
    logic [c_PW-1:0]       w_high_last;

    // tx_len is widened before the compare so large values clamp instead of wrapping
    always_comb begin
        if ({24'd0, bus.tx_len} > 32'(MAX_BYTES)) begin
            w_nbits = c_BW'(c_DATA_W);
        end else begin
            w_nbits = c_BW'({bus.tx_len, 3'b000});
        end
    end

    // A '1' is a short low pulse followed by a long release; a '0' is the reverse
    always_comb begin
        w_low_last  = r_shift[c_DATA_W-1] ? c_SHORT_LAST : c_LONG_LAST;
        w_high_last = r_shift[c_DATA_W-1] ? c_LONG_LAST  : c_SHORT_LAST;
    end

    always_ff @(posedge sample_clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_bits    <= '0;
            r_shift   <= '0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_bits    <= w_bits_nxt;
            r_shift   <= w_shift_nxt;
            // Outputs are decoded from the current state, one edge behind it
            r_data_oe <= (r_state == S_BIT_LOW) || (r_state == S_STOP_LOW);
            r_busy    <= (r_state != S_IDLE);
            r_done    <= (r_state == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + c_PW'(1);
        w_bits_nxt  = r_bits;
        w_shift_nxt = r_shift;

        case (r_state)
            S_IDLE: begin
                w_phase_nxt = '0;
                if (bus.start && (bus.tx_len != 8'd0)) begin
                    w_shift_nxt = bus.tx_data;
                    w_bits_nxt  = w_nbits;
`ifdef N64_TX_GUARD_EN
                    w_state_nxt = S_GUARD;
`else
                    w_state_nxt = S_BIT_LOW;
`endif
                end
            end

`ifdef N64_TX_GUARD_EN
            S_GUARD: begin
                if (r_phase == c_GUARD_LAST) begin
                    w_phase_nxt = '0;
                    w_state_nxt = S_BIT_LOW;
                end
            end
`endif

            S_BIT_LOW: begin
                if (r_phase == w_low_last) begin
                    w_phase_nxt = '0;
                    w_state_nxt = S_BIT_HIGH;
                end
            end

            S_BIT_HIGH: begin
                if (r_phase == w_high_last) begin
                    w_phase_nxt = '0;
                    w_shift_nxt = {r_shift[c_DATA_W-2:0], 1'b0};
                    w_bits_nxt  = r_bits - c_BW'(1);
                    w_state_nxt = (r_bits == c_BW'(1)) ? S_STOP_LOW : S_BIT_LOW;
                end
            end

            S_STOP_LOW: begin
                if (r_phase == c_STOP_LAST) begin
                    w_phase_nxt = '0;
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_phase_nxt = '0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_phase_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.data_oe = r_data_oe;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_n64_response_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_n64_response_tx
// Brief    : Directed bench for n64_response_tx with a per-edge expected
//            waveform built from the line-coding rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_n64_response_tx;

    localparam int MAXB = 4;
    localparam int C    = 4;
    localparam int NE   = 4096;
`ifdef N64_TX_GUARD_EN
    localparam int G = 2 * C;
`else
    localparam int G = 0;
`endif

    logic sample_clk = 1'b0;
    logic rst        = 1'b1;
    int   edge_n     = 0;
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   done_cnt   = 0;
    int   last_done  = -1;

    bit   e_oe   [NE];
    bit   e_busy [NE];
    bit   e_done [NE];

    always #5 sample_clk = ~sample_clk;

    n64_response_tx_if #(.MAX_BYTES(MAXB)) bus();

    n64_response_tx #(
        .MAX_BYTES   (MAXB),
        .CLKS_PER_US (C),
        .GUARD_US    (2)
    ) dut (
        .sample_clk (sample_clk),
        .rst        (rst),
        .bus        (bus)
    );

    always @(posedge sample_clk) edge_n <= edge_n + 1;

    // Expected line activity for a frame whose start is sampled at edge e0
    task automatic plan(input int e0, input logic [31:0] d, input int len);
        int nb;
        int t;
        int hi;
        nb = ((len > MAXB) ? MAXB : len) * 8;
        if (nb == 0) return;
        t = e0 + 1;
        for (int g = 0; g < G; g++) begin
            e_oe[t] = 0; e_busy[t] = 1; e_done[t] = 0; t++;
        end
        for (int i = 0; i < nb; i++) begin
            hi = d[31-i] ? C : 3 * C;
            for (int k = 0; k < 4 * C; k++) begin
                e_oe[t] = (k < hi); e_busy[t] = 1; e_done[t] = 0; t++;
            end
        end
        for (int k = 0; k < 2 * C; k++) begin
            e_oe[t] = 1; e_busy[t] = 1; e_done[t] = 0; t++;
        end
        e_oe[t] = 0; e_busy[t] = 1; e_done[t] = 1;
    endtask

    task automatic clear_from(input int e);
        for (int i = e; i < NE; i++) begin
            e_oe[i] = 0; e_busy[i] = 0; e_done[i] = 0;
        end
    endtask

    always @(posedge sample_clk) begin
        #1;
        if (edge_n >= 1 && edge_n < NE) begin
            n_tests++;
            if (bus.data_oe !== e_oe[edge_n] || bus.busy !== e_busy[edge_n] ||
                bus.done !== e_done[edge_n]) begin
                n_fail++;
                $display("FAIL waveform edge %0d: oe/busy/done got %b%b%b required %b%b%b",
                         edge_n, bus.data_oe, bus.busy, bus.done,
                         e_oe[edge_n], e_busy[edge_n], e_done[edge_n]);
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                last_done = edge_n;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Returns at the falling edge that follows edge tgt
    task automatic goto(input int tgt);
        while (edge_n < tgt) @(negedge sample_clk);
    endtask

    // Called at a falling edge; start is sampled by the next rising edge
    task automatic send(input logic [31:0] d, input int len, output int e0);
        e0            = edge_n + 1;
        bus.start     = 1'b1;
        bus.tx_data   = d;
        bus.tx_len    = 8'(len);
        plan(e0, d, len);
        @(negedge sample_clk);
        bus.start     = 1'b0;
    endtask

    initial begin
        int e0;
        int e1;
        int d0;

        for (int i = 0; i < NE; i++) begin
            e_oe[i] = 0; e_busy[i] = 0; e_done[i] = 0;
        end
        bus.start   = 1'b0;
        bus.tx_data = '0;
        bus.tx_len  = '0;

        repeat (3) @(negedge sample_clk);
        check("reset_oe",   int'(bus.data_oe), 0);
        check("reset_busy", int'(bus.busy),    0);
        check("reset_done", int'(bus.done),    0);
        rst = 1'b0;
        @(negedge sample_clk);

        // One '1' then seven '0's
        d0 = done_cnt;
        send(32'h8000_0000, 1, e0);
        goto(e0 + G);
        check("t1_oe_before_first", int'(bus.data_oe), 0);
        goto(e0 + 1 + G);
        check("t1_first_oe", int'(bus.data_oe), 1);
        goto(e0 + 138 + G);
        check("t1_done_edge", last_done - e0, 137 + G);
        check("t1_busy_after", int'(bus.busy), 0);
        check("t1_done_count", done_cnt - d0, 1);

        // Full-width all-ones payload
        @(negedge sample_clk);
        send(32'hFFFF_FFFF, 4, e0);
        goto(e0 + 525 + G);
        check("t2_done_edge", last_done - e0, 521 + G);

        // Payload and start disturbed mid-frame must not matter
        d0 = done_cnt;
        send(32'hA500_0000, 1, e0);
        goto(e0 + 49);
        bus.start   = 1'b1;
        bus.tx_data = 32'h0;
        bus.tx_len  = 8'd4;
        @(negedge sample_clk);
        bus.start   = 1'b0;
        goto(e0 + 150 + G);
        check("t3_done_edge", last_done - e0, 137 + G);
        check("t3_done_count", done_cnt - d0, 1);

        // Reset during bit 1, then a clean restart two edges later
        d0 = done_cnt;
        send(32'h5500_0000, 1, e0);
        goto(e0 + 19);
        clear_from(e0 + 20);
        rst = 1'b1;
        @(negedge sample_clk);
        rst = 1'b0;
        check("t4_rst_oe",   int'(bus.data_oe), 0);
        check("t4_rst_busy", int'(bus.busy),    0);
        goto(e0 + 21);
        send(32'hC33C_0000, 2, e1);
        check("t4_restart_edge", e1 - e0, 22);
        goto(e1 + 270 + G);
        check("t4_done_count", done_cnt - d0, 1);
        check("t4_done_edge", last_done - e1, 265 + G);

        // Zero length is ignored
        d0 = done_cnt;
        send(32'hFFFF_FFFF, 0, e0);
        check("t5_busy", int'(bus.busy), 0);
        goto(e0 + 20);
        check("t5_oe", int'(bus.data_oe), 0);
        check("t5_done_count", done_cnt - d0, 0);

        // Oversize length clamps to MAX_BYTES
        send(32'h1234_5678, 9, e0);
        goto(e0 + 525 + G);
        check("t6_done_edge", last_done - e0, 521 + G);

        // Earliest restart, sampled on the edge after done
        d0 = done_cnt;
        send(32'h5A00_0000, 1, e0);
        goto(e0 + 137 + G);
        send(32'h8100_0000, 1, e1);
        check("t7_restart_gap", e1 - e0, 138 + G);
        goto(e1 + 140 + G);
        check("t7_done_edge", last_done - e1, 137 + G);
        check("t7_done_count", done_cnt - d0, 2);

        repeat (4) @(negedge sample_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
